// File: rtl/alu_cmd_issue.sv
// Command FIFO and issue stage in front of an 8-bit combinational ALU.
// Results land in a handshaked output register; an accumulator can stand in for operand A.
module alu_cmd_issue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [7:0]  cmd_a_i,
  input  logic [7:0]  cmd_b_i,
  input  logic        cmd_acc_i,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  output logic [2:0]  alu_op_o,
  input  logic [7:0]  alu_res_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [7:0]  res_data_o,
  output logic [2:0]  res_op_o,
  output logic [7:0]  acc_o,
  output logic [15:0] issued_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc;
  } entry_t;

  entry_t          mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [1:0]      rst_sync_r;
  logic            rst_n_s;
  logic            empty_s;
  logic            push_s;
  logic            issue_s;
  logic            out_free_s;
  entry_t          head_s;
  logic [7:0]      acc_r;
  logic [7:0]      res_data_r;
  logic [2:0]      res_op_r;
  logic            res_valid_r;
  logic [15:0]     issued_cnt_r;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_r[1];

  assign empty_s     = (count_r == '0);
  assign cmd_ready_o = (count_r != DEPTH_C);
  assign push_s      = cmd_valid_i && cmd_ready_o;
  assign head_s      = mem_r[rd_ptr_r];
  // The output register is free when empty or being drained this cycle.
  assign out_free_s  = (state_r == ST_IDLE) || res_ready_i;
  assign issue_s     = !empty_s && out_free_s;

  always_comb begin
    alu_a_o  = 8'h00;
    alu_b_o  = 8'h00;
    alu_op_o = 3'b000;
    if (!empty_s) begin
      alu_a_o  = head_s.acc ? acc_r : head_s.a;
      alu_b_o  = head_s.b;
      alu_op_o = head_s.op;
    end else begin
      alu_a_o  = 8'h00;
      alu_b_o  = 8'h00;
      alu_op_o = 3'b000;
    end
  end

  // State tracks occupancy of the result register: idle, freshly loaded, or held.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN, ST_STALL: begin
        if (issue_s) begin
          state_nxt_s = ST_RUN;
        end else if (res_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STALL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i, acc: cmd_acc_i};
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, issue_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      res_data_r   <= 8'h00;
      res_op_r     <= 3'b000;
      res_valid_r  <= 1'b0;
      acc_r        <= 8'h00;
      issued_cnt_r <= 16'h0000;
    end else if (issue_s) begin
      res_data_r   <= alu_res_i;
      res_op_r     <= head_s.op;
      res_valid_r  <= 1'b1;
      acc_r        <= alu_res_i;
      issued_cnt_r <= issued_cnt_r + 16'd1;
    end else if (res_valid_r && res_ready_i) begin
      res_valid_r  <= 1'b0;
    end else begin
      res_valid_r  <= res_valid_r;
    end
  end

  assign res_data_o   = res_data_r;
  assign res_op_o     = res_op_r;
  assign res_valid_o  = res_valid_r;
  assign acc_o        = acc_r;
  assign issued_cnt_o = issued_cnt_r;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Randomised and directed bench for alu_cmd_issue against a queue-based reference model.
module tb_alu_cmd_issue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_acc;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic [7:0]  alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic        res_valid, res_ready;
  logic [7:0]  res_data, acc;
  logic [2:0]  res_op;
  logic [15:0] issued_cnt;

  int vectors = 0;
  int miscompares = 0;

  alu_cmd_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_acc_i(cmd_acc),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_res_i(alu_res),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_op_o(res_op),
    .acc_o(acc), .issued_cnt_o(issued_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return (a >= b) ? a - b : b - a;
      3'd2:    return a << b[2:0];
      3'd3:    return a >> b[2:0];
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return (a == b) ? 8'h01 : 8'h00;
    endcase
  endfunction

  // The ALU the block feeds.
  always_comb alu_res = alu_f(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc;
  } cmd_t;

  cmd_t        q[$];
  logic [7:0]  m_acc, m_res;
  logic [2:0]  m_op;
  logic        m_valid;
  logic [15:0] m_cnt;

  // Reference: a queue of pending commands and a one-deep result slot.
  always @(posedge clk or negedge reset_n) begin : model_blk
    cmd_t c;
    logic take, iss;
    if (!reset_n) begin
      q.delete();
      m_acc = 8'h00; m_res = 8'h00; m_op = 3'b000; m_valid = 1'b0; m_cnt = 16'h0000;
    end else begin
      take = cmd_valid && (q.size() < DEPTH);
      iss  = (q.size() != 0) && (!m_valid || res_ready);
      if (iss) begin
        c       = q.pop_front();
        m_res   = alu_f(c.op, c.acc ? m_acc : c.a, c.b);
        m_op    = c.op;
        m_acc   = m_res;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 16'd1;
      end else if (m_valid && res_ready) begin
        m_valid = 1'b0;
      end
      if (take) q.push_back('{op: cmd_op, a: cmd_a, b: cmd_b, acc: cmd_acc});
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("cmd_ready", {15'd0, cmd_ready}, {15'd0, (q.size() < DEPTH)});
      chk("res_valid", {15'd0, res_valid}, {15'd0, m_valid});
      chk("res_data", {8'd0, res_data}, {8'd0, m_res});
      chk("res_op", {13'd0, res_op}, {13'd0, m_op});
      chk("acc", {8'd0, acc}, {8'd0, m_acc});
      chk("issued_cnt", issued_cnt, m_cnt);
      if (q.size() != 0) begin
        chk("alu_a", {8'd0, alu_a}, {8'd0, q[0].acc ? m_acc : q[0].a});
        chk("alu_b", {8'd0, alu_b}, {8'd0, q[0].b});
        chk("alu_op", {13'd0, alu_op}, {13'd0, q[0].op});
      end else begin
        chk("alu_idle", {alu_a, alu_b}, 16'h0000);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ac);
    cmd_valid = v; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = ac;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    res_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    res_ready = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b1;
    idle(4);
    chk("rst_valid", {15'd0, res_valid}, 16'd0);
    chk("rst_data", {8'd0, res_data}, 16'd0);
    chk("rst_acc", {8'd0, acc}, 16'd0);
    chk("rst_cnt", issued_cnt, 16'd0);
    chk("rst_ready", {15'd0, cmd_ready}, 16'd1);

    // Single ADD: result visible two edges after acceptance.
    drive(1'b1, 3'd0, 8'h05, 8'h07, 1'b0); tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    chk("add_early", {15'd0, res_valid}, 16'd0);
    tick();
    chk("add_valid", {15'd0, res_valid}, 16'd1);
    chk("add_data", {8'd0, res_data}, 16'h000C);
    chk("add_op", {13'd0, res_op}, 16'd0);
    chk("add_acc", {8'd0, acc}, 16'h000C);
    chk("add_cnt", issued_cnt, 16'd1);

    // Accumulator chain, back-to-back.
    drive(1'b1, 3'd0, 8'h03, 8'h04, 1'b0); tick();
    drive(1'b1, 3'd0, 8'h00, 8'h10, 1'b1); tick();
    chk("chain0", {8'd0, res_data}, 16'h0007);
    drive(1'b1, 3'd6, 8'h00, 8'hFF, 1'b1); tick();
    chk("chain1", {8'd0, res_data}, 16'h0017);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0); tick();
    chk("chain2", {8'd0, res_data}, 16'h00E8);
    chk("chain_cnt", issued_cnt, 16'd4);

    // Backpressure: one issues, four queue, sixth is refused.
    idle(2);
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd0, 8'(i + 1), 8'h10, 1'b0); tick();
    end
    chk("full_ready", {15'd0, cmd_ready}, 16'd0);
    chk("full_data", {8'd0, res_data}, 16'h0011);
    drive(1'b1, 3'd0, 8'h06, 8'h10, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_ready", {15'd0, cmd_ready}, 16'd0);
      chk("stall_data", {8'd0, res_data}, 16'h0011);
      chk("stall_acc", {8'd0, acc}, 16'h0011);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drain", {8'd0, res_data}, 16'(8'h12 + i));
      if (i == 1) drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    end

    // Edge cases of the ALU results.
    idle(2);
    drive(1'b1, 3'd0, 8'hFF, 8'h01, 1'b0); tick();
    drive(1'b1, 3'd1, 8'h03, 8'h08, 1'b0); tick();
    chk("add_wrap", {8'd0, res_data}, 16'h0000);
    drive(1'b1, 3'd7, 8'h5A, 8'h5A, 1'b0); tick();
    chk("sub_abs", {8'd0, res_data}, 16'h0005);
    drive(1'b1, 3'd2, 8'h81, 8'h09, 1'b0); tick();
    chk("eql", {8'd0, res_data}, 16'h0001);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0); tick();
    chk("sll", {8'd0, res_data}, 16'h0002);

    // Reset with a held result and three queued commands.
    idle(2);
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd0, 8'h40, 8'(i), 1'b0); tick();
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {15'd0, res_valid}, 16'd0);
    chk("mid_rst_acc", {8'd0, acc}, 16'd0);
    chk("mid_rst_cnt", issued_cnt, 16'd0);
    chk("mid_rst_ready", {15'd0, cmd_ready}, 16'd1);
    tick(); tick();
    reset_n = 1'b1;
    idle(4);
    chk("post_rst_valid", {15'd0, res_valid}, 16'd0);
    drive(1'b1, 3'd0, 8'h02, 8'h03, 1'b0); tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0); tick();
    chk("post_rst_data", {8'd0, res_data}, 16'h0005);
    chk("post_rst_cnt", issued_cnt, 16'd1);
    tick();
    chk("post_rst_drained", {15'd0, res_valid}, 16'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)));
      res_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issue.md
# alu_cmd_issue

Command buffer and issue stage placed directly upstream of the 8-bit combinational ALU. Accepts `{op, a, b}` commands over a valid/ready handshake and queues them in a DEPTH-entry FIFO. Drives the head command onto the ALU inputs, captures the ALU result into an output register with its own valid/ready handshake, and keeps an 8-bit accumulator that later commands can use as operand A.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: FIFO can accept.
- `cmd_op_i` in 3: ALU op encoding, passed through unchanged:
  - 000 ADD, 001 \|SUB\|, 010 SLL, 011 SRL
  - 100 AND, 101 OR, 110 XOR, 111 EQL
- `cmd_a_i` in 8: operand A.
- `cmd_b_i` in 8: operand B.
- `cmd_acc_i` in 1: substitute the accumulator for operand A at issue.
- `alu_a_o` out 8: to ALU `a_i`.
- `alu_b_o` out 8: to ALU `b_i`.
- `alu_op_o` out 3: to ALU `op_i`.
- `alu_res_i` in 8: from ALU `alu_o`, combinational in the same cycle.
- `res_valid_o` out 1: result register holds data.
- `res_ready_i` in 1: downstream consumes.
- `res_data_o` out 8: captured result.
- `res_op_o` out 3: op that produced `res_data_o`.
- `acc_o` out 8: current accumulator.
- `issued_cnt_o` out 16: count of issued commands; wraps at 0xFFFF→0.

## Operation
**FIFO**
- Write pointer, read pointer and count are each `log2(DEPTH)`/`log2(DEPTH)+1` bits; pointers wrap modulo DEPTH.
- `cmd_ready_o = (count != DEPTH)`. There is no bypass when full, even if a pop happens in the same cycle.
- A push occurs on an edge where `cmd_valid_i && cmd_ready_o`. The entry stores `{op, a, b, acc}`.

**ALU drive**
- ALU outputs are always driven from the FIFO head:
  - `alu_a_o = head.acc ? acc : head.a`
  - `alu_b_o = head.b`
  - `alu_op_o = head.op`
- When the FIFO is empty, the ALU outputs drive all zeros.

**Issue**
- Issue condition: `issue = (count != 0) && (!res_valid_o || res_ready_i)`.
- On an issue edge:
  - Pop the head.
  - `res_data_o <= alu_res_i`, `res_op_o <= head.op`, `res_valid_o <= 1`.
  - `acc <= alu_res_i`.
  - `issued_cnt_o` increments.
- On a non-issue edge where `res_valid_o && res_ready_i`: `res_valid_o <= 0`.
- Push and pop in the same cycle leave `count` unchanged.

**State machine** (2-bit, exposed only through its behaviour)
- States:
  - IDLE: `count == 0`, `res_valid_o == 0`.
  - RUN: issuing every cycle.
  - STALL: `res_valid_o && !res_ready_i`, holding.
- Transitions:
  - IDLE→RUN on `count != 0`.
  - RUN→STALL when `res_ready_i` is low while `res_valid_o` is high.
  - STALL→RUN on `res_ready_i`.
  - RUN→IDLE when the FIFO drains and the result is consumed.
- While in STALL:
  - `res_data_o`, `res_op_o` and `acc` are held stable.
  - The head is not popped.
  - Pushes are still accepted until the FIFO is full.

**Arithmetic**
- The block never modifies ALU results.
- The ADD carry is dropped: `0xFF + 0x01` yields `0x00`.

**Reset** (asynchronous assert, synchronous release)
- Reset drives all of the following low/zero:
  - `count`, both pointers, `acc_o`, `res_data_o`, `res_op_o`, `res_valid_o`, `issued_cnt_o`, state.
- `cmd_ready_o` = 1 once reset is released.
- Asserting reset mid-operation discards all queued commands and any pending result. Nothing from before reset appears afterwards.

## Timing
- **Latency:** a command accepted at edge E0 becomes head after E0. It issues at E1 when the output is free, so `res_valid_o` is high in the cycle following E1. Minimum latency is 2 edges from acceptance to result register.
- **Throughput:** one command per cycle when `res_ready_i` is held high.
- **Accumulator dependency:** `acc` updates at the issue edge, so an acc-flagged command issued the next cycle sees the new value. There is no hazard stall.
- **Full FIFO:** `cmd_ready_o` deasserts in the cycle after the DEPTH-th push. It reasserts in the cycle after a pop.
- **Counter wrap:** `issued_cnt_o` wraps to 0 with no flag.

## Test plan
- **Reset values:** assert `reset_n=0` asynchronously mid-cycle.
  - All outputs must read 0 and `cmd_ready_o` must be 1 after release.
- **Single ADD:** push `{000, 0x05, 0x07}` with `res_ready_i=1`, ALU model attached.
  - `res_valid_o` goes high 2 edges after acceptance with `res_data_o=0x0C`, `res_op_o=000`, `acc_o=0x0C`, `issued_cnt_o=1`.
- **Accumulator chain:** push ADD 0x03+0x04, then ADD acc+0x10, then XOR acc^0xFF, back-to-back.
  - Results must be 0x07, 0x17, 0xE8 on consecutive cycles.
- **Backpressure and full:** hold `res_ready_i=0`, push 6 commands with DEPTH=4.
  - 1 command issues, 4 commands queue, and `cmd_ready_o` drops on the 6th.
  - `res_data_o` stays stable.
  - Releasing `res_ready_i` drains all 5 in order, one per cycle.
- **Overflow and edge ops:**
  - ADD 0xFF+0x01 → 0x00.
  - SUB 0x03,0x08 → 0x05.
  - EQL 0x5A,0x5A → 0x01.
  - SLL 0x81 by 0x09 → 0x02, using b[2:0].
- **Reset mid-stream:** assert reset with 3 commands queued and the result held.
  - After release, `res_valid_o=0` and `count=0`.
  - The next push produces only its own result.
